// File: rtl/seq_alu_if.sv
// Valid/ready operation and result channels of the sequential ALU.
interface seq_alu_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        Operation;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;
    logic              Illegal;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, Illegal
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, Illegal
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle execute unit: single-cycle arithmetic/logic/compare/branch ops,
// shifts iterate one bit per cycle. Results are registered and held until taken.
module seq_alu #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input logic   clk,
    input logic   reset,
    seq_alu_if.slave bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    logic [DATA_W-1:0]  res_c;
    logic               zero_c;
    logic               illegal_c;
    logic               is_shift_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic [DATA_W-1:0]  step_c;
    logic               accept;

    assign bus.in_ready  = !reset &&
                           ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready));
    assign bus.out_valid = (state_q == StDone);
    assign bus.ALUResult = acc_q;
    assign bus.Zero      = zero_q;
    assign bus.Illegal   = illegal_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign shamt_c = bus.SrcB[SHAMT_W-1:0];

    // Single-cycle result; shifts yield SrcA here, which is final only when shamt is 0.
    always_comb begin
        res_c      = '0;
        zero_c     = 1'b0;
        illegal_c  = 1'b0;
        is_shift_c = 1'b0;
        case (bus.Operation)
            4'b0000: res_c = bus.SrcA + bus.SrcB;
            4'b0001: res_c = bus.SrcA - bus.SrcB;
            4'b0010: res_c = bus.SrcA ^ bus.SrcB;
            4'b0011: res_c = bus.SrcA | bus.SrcB;
            4'b0100: res_c = bus.SrcA & bus.SrcB;
            4'b0101: res_c = {{(DATA_W-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
            4'b0110, 4'b0111, 4'b1000: begin
                res_c      = bus.SrcA;
                is_shift_c = 1'b1;
            end
            4'b1010: zero_c = (bus.SrcA != bus.SrcB);
            4'b1011: zero_c = ($signed(bus.SrcA) < $signed(bus.SrcB));
            4'b1100: zero_c = ($signed(bus.SrcA) >= $signed(bus.SrcB));
            4'b1101: zero_c = (bus.SrcA == bus.SrcB);
            default: illegal_c = 1'b1;
        endcase
        if (zero_c) begin
            res_c = {{(DATA_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        step_c = '0;
        case (op_q)
            4'b0110: step_c = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
            4'b0111: step_c = {1'b0, acc_q[DATA_W-1:1]};
            default: step_c = {acc_q[DATA_W-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (accept) begin
            acc_d     = res_c;
            op_d      = bus.Operation;
            zero_d    = zero_c;
            illegal_d = illegal_c;
            cnt_d     = shamt_c;
            state_d   = (is_shift_c && (shamt_c != '0)) ? StShift : StDone;
        end else if (state_q == StShift) begin
            acc_d = step_c;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
                state_d = StDone;
            end
        end else if ((state_q == StDone) && bus.out_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, hand-written
// backpressure/back-to-back/reset sequences, and random ops against a model.
module tb_seq_alu;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.DATA_W(32)) bus ();

    seq_alu #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: direct arithmetic per op code; latency = shift amount for shifts.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output logic ill,
                         output int lat);
        int sh;
        sh  = int'(b % 32);
        res = 0;
        z   = 0;
        ill = 0;
        lat = 0;
        case (op)
            4'd0:  res = a + b;
            4'd1:  res = a - b;
            4'd2:  res = a ^ b;
            4'd3:  res = a | b;
            4'd4:  res = a & b;
            4'd5:  res = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd6:  begin res = $signed(a) >>> sh; lat = sh; end
            4'd7:  begin res = a >> sh; lat = sh; end
            4'd8:  begin res = a << sh; lat = sh; end
            4'd10: z = (a != b);
            4'd11: z = ($signed(a) < $signed(b));
            4'd12: z = ($signed(a) >= $signed(b));
            4'd13: z = (a == b);
            default: ill = 1;
        endcase
        if (z) res = 1;
    endtask

    // Present one op, wait for its result (out_ready assumed 1), return what was observed.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output logic ill,
                          output int cyc);
        int n;
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        n = 0;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.SrcA     = ~a;
            cyc++;
        end while (!bus.out_valid && cyc < 100);
        if (!bus.out_valid) check("result_timeout", 32'(bus.out_valid), 32'd1);
        res = bus.ALUResult;
        z   = bus.Zero;
        ill = bus.Illegal;
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] r, er, ra, rb;
        logic        z, ez, il, eil;
        int          cyc, elat;
        logic [3:0]  rop;
        bit          stale;

        vecs.push_back('{4'b0000, 32'hFFFF_FFFF, 32'd1,      32'h0,         1'b0, 1'b0, 0});
        vecs.push_back('{4'b0001, 32'd5,         32'd7,      32'hFFFF_FFFE, 1'b0, 1'b0, 0});
        vecs.push_back('{4'b0110, 32'h8000_0000, 32'd4,      32'hF800_0000, 1'b0, 1'b0, 4});
        vecs.push_back('{4'b0111, 32'h8000_0000, 32'd4,      32'h0800_0000, 1'b0, 1'b0, 4});
        vecs.push_back('{4'b1000, 32'd3,         32'h20,     32'd3,         1'b0, 1'b0, 0});
        vecs.push_back('{4'b1011, 32'hFFFF_FFFF, 32'd1,      32'd1,         1'b1, 1'b0, 0});
        vecs.push_back('{4'b1100, 32'hFFFF_FFFF, 32'd1,      32'd0,         1'b0, 1'b0, 0});
        vecs.push_back('{4'b1101, 32'h1234,      32'h1234,   32'd1,         1'b1, 1'b0, 0});
        vecs.push_back('{4'b1010, 32'h1234,      32'h1234,   32'd0,         1'b0, 1'b0, 0});
        vecs.push_back('{4'b0101, 32'hFFFF_FFFF, 32'd1,      32'd1,         1'b0, 1'b0, 0});
        vecs.push_back('{4'b0011, 32'hF0,        32'h0F,     32'hFF,        1'b0, 1'b0, 0});
        vecs.push_back('{4'b1110, 32'd7,         32'd7,      32'd0,         1'b0, 1'b1, 0});
        vecs.push_back('{4'b0000, 32'd2,         32'd3,      32'd5,         1'b0, 1'b0, 0});
        vecs.push_back('{4'b1001, 32'd1,         32'd1,      32'd0,         1'b0, 1'b1, 0});
        vecs.push_back('{4'b1111, 32'd1,         32'd1,      32'd0,         1'b0, 1'b1, 0});
        vecs.push_back('{4'b0111, 32'hFFFF_FFFF, 32'h3F,     32'd1,         1'b0, 1'b0, 31});
        vecs.push_back('{4'b1000, 32'd1,         32'd31,     32'h8000_0000, 1'b0, 1'b0, 31});
        vecs.push_back('{4'b0110, 32'h8000_0001, 32'd1,      32'hC000_0000, 1'b0, 1'b0, 1});

        bus.in_valid  = 1'b0;
        bus.Operation = 4'd0;
        bus.SrcA      = '0;
        bus.SrcB      = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    bus.ALUResult,      32'd0);
        check("rst_zero",      32'(bus.Zero),      32'd0);
        check("rst_illegal",   32'(bus.Illegal),   32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, il, cyc);
            check($sformatf("vec%0d_result", i),  r,           vecs[i].res);
            check($sformatf("vec%0d_zero", i),    32'(z),      32'(vecs[i].zero));
            check($sformatf("vec%0d_illegal", i), 32'(il),     32'(vecs[i].ill));
            check($sformatf("vec%0d_latency", i), 32'(cyc),    32'(vecs[i].lat + 1));
        end

        // Backpressure: xor result held for 3 cycles, then and accepted on the retire edge.
        @(negedge clk);
        bus.out_ready = 1'b0;
        run_op(4'b0010, 32'hF0F0, 32'hFF00, r, z, il, cyc);
        check("bp_xor", r, 32'h0FF0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid",  32'(bus.out_valid), 32'd1);
            check("bp_hold_result", bus.ALUResult,      32'h0FF0);
            check("bp_in_ready",    32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.Operation = 4'b0100;
        bus.SrcA      = 32'hF0F0;
        bus.SrcB      = 32'hFF00;
        #1;
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b_valid",  32'(bus.out_valid), 32'd1);
        check("b2b_result", bus.ALUResult,      32'hF000);

        // Throughput: one add per cycle with out_ready held high.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'b1;
            bus.Operation = 4'b0000;
            bus.SrcA      = 32'(100 * i);
            bus.SrcB      = 32'd1;
            @(negedge clk);
            check("tp_valid",  32'(bus.out_valid), 32'd1);
            check("tp_result", bus.ALUResult,      32'(100 * i + 1));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Reset on the 5th shift cycle of slli by 20: no partial result may surface.
        bus.in_valid  = 1'b1;
        bus.Operation = 4'b1000;
        bus.SrcA      = 32'd1;
        bus.SrcB      = 32'd20;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rs_in_ready_forced", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("rs_valid",  32'(bus.out_valid), 32'd0);
        check("rs_result", bus.ALUResult,      32'd0);
        check("rs_zero",   32'(bus.Zero),      32'd0);
        reset = 1'b0;
        #1;
        check("rs_in_ready", 32'(bus.in_ready), 32'd1);
        stale = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        check("rs_no_stale", 32'(stale), 32'd0);

        // Random ops against the model.
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? ra : $urandom;
            model(rop, ra, rb, er, ez, eil, elat);
            run_op(rop, ra, rb, r, z, il, cyc);
            check($sformatf("rnd%0d_op%0d_result", i, rop), r, er);
            check($sformatf("rnd%0d_op%0d_zero", i, rop), 32'(z), 32'(ez));
            check($sformatf("rnd%0d_op%0d_illegal", i, rop), 32'(il), 32'(eil));
            check($sformatf("rnd%0d_op%0d_latency", i, rop), 32'(cyc), 32'(elat + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
